// File: rtl/sr_bank_arbiter.sv
// sr_bank_arbiter
//   Two-requester arbiter that writes single bits of an 8-bit SR flip-flop
//   bank. A granted write is converted into a one-cycle set or reset strobe
//   on the addressed bit, and a shadow copy of the bank state is kept in q.
//   Each transaction walks IDLE -> DRIVE -> ACK, one state per clock.
//   Simultaneous requests are resolved by a round-robin pointer.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   req0/req1          write requests
//   addr0/addr1        target bit index (3 bits)
//   d0/d1              value to store at the addressed bit
//   clr_all            (only with SR_BANK_CLEAR_ALL_EN) clear the whole bank
//   ack0/ack1          one-cycle completion pulse, asserted in ACK
//   s, r               per-bit set / reset strobes, asserted in DRIVE
//   q                  shadow of the bank state
//   busy               high while not in IDLE
//
// Configuration
//   SR_BANK_CLEAR_ALL_EN  adds clr_all. A clear sampled in IDLE beats both
//                         requests, strobes r = q, ends with q = 0, passes
//                         through ACK without an ack and leaves rr alone.

module sr_bank_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic [2:0] addr0,
  input  logic [2:0] addr1,
  input  logic       d0,
  input  logic       d1,
`ifdef SR_BANK_CLEAR_ALL_EN
  input  logic       clr_all,
`endif
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] s,
  output logic [7:0] r,
  output logic [7:0] q,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, DRIVE, ACK} state_t;

  state_t     state;
  logic       rr;      // requester that wins the next collision
  logic       gnt;     // requester owning the current transaction
  logic [2:0] a_q;     // latched address
  logic       d_q;     // latched data
  logic       clr_q;   // current transaction is a clear-all

  logic       clr_hit;
  logic       pick;
  logic [2:0] sel_a;
  logic       sel_d;
  logic [7:0] onehot;

`ifdef SR_BANK_CLEAR_ALL_EN
  assign clr_hit = clr_all;
`else
  assign clr_hit = 1'b0;
`endif

  // Grant decode: a lone request wins outright, a collision goes to rr.
  always_comb begin
    pick   = 1'b0;
    if (req0 && req1) pick = rr;
    else if (req1)    pick = 1'b1;
    sel_a  = pick ? addr1 : addr0;
    sel_d  = pick ? d1 : d0;
    onehot = 8'd1 << sel_a;
  end

  assign busy = (state != IDLE);

  // Strobes are registered on the IDLE->DRIVE edge from the current q; q
  // cannot change before DRIVE ends, so they match q as seen during DRIVE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rr    <= 1'b0;
      gnt   <= 1'b0;
      a_q   <= 3'd0;
      d_q   <= 1'b0;
      clr_q <= 1'b0;
      q     <= 8'h00;
      s     <= 8'h00;
      r     <= 8'h00;
      ack0  <= 1'b0;
      ack1  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          s    <= 8'h00;
          r    <= 8'h00;
          ack0 <= 1'b0;
          ack1 <= 1'b0;
          if (clr_hit) begin
            clr_q <= 1'b1;
            r     <= q;
            state <= DRIVE;
          end else if (req0 || req1) begin
            clr_q <= 1'b0;
            gnt   <= pick;
            a_q   <= sel_a;
            d_q   <= sel_d;
            s     <= onehot & {8{ sel_d & ~q[sel_a]}};
            r     <= onehot & {8{~sel_d &  q[sel_a]}};
            state <= DRIVE;
          end
        end
        DRIVE: begin
          s <= 8'h00;
          r <= 8'h00;
          if (clr_q) begin
            q <= 8'h00;
          end else begin
            q[a_q] <= d_q;
            ack0   <= ~gnt;
            ack1   <= gnt;
            rr     <= ~gnt;
          end
          state <= ACK;
        end
        ACK: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          clr_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// Directed bench for sr_bank_arbiter. Inputs change on the falling edge,
// outputs are sampled on the falling edge; each task starts and ends at a
// falling edge with the DUT in IDLE.
module tb_sr_bank_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [2:0] addr0 = 3'd0, addr1 = 3'd0;
  logic       d0 = 1'b0, d1 = 1'b0;
`ifdef SR_BANK_CLEAR_ALL_EN
  logic       clr_all = 1'b0;
`endif
  logic       ack0, ack1, busy;
  logic [7:0] s, r, q;

  int tests = 0;
  int fails = 0;

  sr_bank_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1), .d0(d0), .d1(d1),
`ifdef SR_BANK_CLEAR_ALL_EN
    .clr_all(clr_all),
`endif
    .ack0(ack0), .ack1(ack1), .s(s), .r(r), .q(q), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stimulus only: one complete single-requester write.
  task automatic do_write(input bit who, input logic [2:0] a, input bit d);
    if (who) begin req1 = 1'b1; addr1 = a; d1 = d; end
    else     begin req0 = 1'b1; addr0 = a; d0 = d; end
    @(negedge clk);              // DRIVE
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);              // ACK
    @(negedge clk);              // IDLE
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if ({q, s, r, ack0, ack1, busy} !== {8'h00, 8'h00, 8'h00, 3'b000}) begin
      fails++;
      $display("FAIL reset: q=%h s=%h r=%h ack=%b%b busy=%b, want all 0", q, s, r, ack0, ack1, busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if ({s, r, ack0, ack1, busy} !== 19'd0) begin
      fails++;
      $display("FAIL idle_no_req: s=%h r=%h ack=%b%b busy=%b, want 0", s, r, ack0, ack1, busy);
    end
  endtask

  task automatic test_set_bit5();
    req0 = 1'b1; addr0 = 3'd5; d0 = 1'b1;
    @(negedge clk);                        // cycle k+1
    req0 = 1'b0;                           // early drop must not abort
    addr0 = 3'd0; d0 = 1'b0;               // post-grant changes ignored
    tests++;
    if ({s, r, ack0, busy} !== {8'h20, 8'h00, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL set5_drive: s=%h r=%h ack0=%b busy=%b, want 20 00 0 1", s, r, ack0, busy);
    end
    @(negedge clk);                        // cycle k+2
    tests++;
    if ({ack0, ack1, q, s, busy} !== {1'b1, 1'b0, 8'h20, 8'h00, 1'b1}) begin
      fails++;
      $display("FAIL set5_ack: ack=%b%b q=%h s=%h busy=%b, want 10 20 00 1", ack0, ack1, q, s, busy);
    end
    @(negedge clk);
    tests++;
    if ({ack0, busy, q} !== {2'b00, 8'h20}) begin
      fails++;
      $display("FAIL set5_idle: ack0=%b busy=%b q=%h, want 0 0 20", ack0, busy, q);
    end
  endtask

  task automatic test_clear_bit5();
    req1 = 1'b1; addr1 = 3'd5; d1 = 1'b0;
    @(negedge clk);
    req1 = 1'b0;
    tests++;
    if ({s, r} !== {8'h00, 8'h20}) begin
      fails++;
      $display("FAIL clr5_drive: s=%h r=%h, want 00 20", s, r);
    end
    @(negedge clk);
    tests++;
    if ({ack0, ack1, q} !== {2'b01, 8'h00}) begin
      fails++;
      $display("FAIL clr5_ack: ack=%b%b q=%h, want 01 00", ack0, ack1, q);
    end
    @(negedge clk);
  endtask

  task automatic test_collision();
    // last grant went to requester 1, so rr points to 0
    req0 = 1'b1; addr0 = 3'd1; d0 = 1'b1;
    req1 = 1'b1; addr1 = 3'd2; d1 = 1'b1;
    @(negedge clk);                        // k+1
    tests++;
    if ({s, r} !== {8'h02, 8'h00}) begin
      fails++;
      $display("FAIL coll_drive0: s=%h r=%h, want 02 00", s, r);
    end
    @(negedge clk);                        // k+2
    tests++;
    if ({ack0, ack1} !== 2'b10) begin
      fails++;
      $display("FAIL coll_ack0: ack=%b%b, want 10", ack0, ack1);
    end
    req0 = 1'b0;
    @(negedge clk);                        // k+3 IDLE, req1 still waiting
    tests++;
    if ({busy, ack0, ack1} !== 3'b000) begin
      fails++;
      $display("FAIL coll_gap: busy=%b ack=%b%b, want 0 00", busy, ack0, ack1);
    end
    @(negedge clk);                        // k+4
    tests++;
    if ({s, busy} !== {8'h04, 1'b1}) begin
      fails++;
      $display("FAIL coll_drive1: s=%h busy=%b, want 04 1", s, busy);
    end
    @(negedge clk);                        // k+5
    tests++;
    if ({ack0, ack1, q} !== {2'b01, 8'h06}) begin
      fails++;
      $display("FAIL coll_ack1: ack=%b%b q=%h, want 01 06", ack0, ack1, q);
    end
    req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_noop();
    do_write(1'b0, 3'd3, 1'b1);            // q = 0E
    req0 = 1'b1; addr0 = 3'd3; d0 = 1'b1;
    @(negedge clk);
    req0 = 1'b0;
    tests++;
    if ({s, r, busy} !== {8'h00, 8'h00, 1'b1}) begin
      fails++;
      $display("FAIL noop_drive: s=%h r=%h busy=%b, want 00 00 1", s, r, busy);
    end
    @(negedge clk);
    tests++;
    if ({ack0, s, r, q} !== {1'b1, 8'h00, 8'h00, 8'h0E}) begin
      fails++;
      $display("FAIL noop_ack: ack0=%b s=%h r=%h q=%h, want 1 00 00 0e", ack0, s, r, q);
    end
    @(negedge clk);
  endtask

  task automatic test_rr_alternate();
    // rr now points to 1 (last grant was requester 0); collision goes to 1
    req0 = 1'b1; addr0 = 3'd4; d0 = 1'b1;
    req1 = 1'b1; addr1 = 3'd6; d1 = 1'b1;
    @(negedge clk);
    tests++;
    if (s !== 8'h40) begin
      fails++;
      $display("FAIL rr_drive: s=%h, want 40", s);
    end
    req1 = 1'b0;
    @(negedge clk);
    tests++;
    if ({ack0, ack1} !== 2'b01) begin
      fails++;
      $display("FAIL rr_ack: ack=%b%b, want 01", ack0, ack1);
    end
    @(negedge clk);                        // IDLE, req0 still pending
    @(negedge clk);
    req0 = 1'b0;
    tests++;
    if (s !== 8'h10) begin
      fails++;
      $display("FAIL rr_second: s=%h, want 10", s);
    end
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (q !== 8'h5E) begin
      fails++;
      $display("FAIL rr_q: q=%h, want 5e", q);
    end
  endtask

  task automatic test_reset_mid();
    req0 = 1'b1; addr0 = 3'd7; d0 = 1'b1;
    @(negedge clk);
    req0 = 1'b0;
    tests++;
    if (s !== 8'h80) begin
      fails++;
      $display("FAIL rstmid_drive: s=%h, want 80", s);
    end
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if ({q, s, r, ack0, ack1, busy} !== 27'd0) begin
      fails++;
      $display("FAIL rstmid_async: q=%h s=%h r=%h ack=%b%b busy=%b, want 0", q, s, r, ack0, ack1, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if ({q, ack0, busy} !== 10'd0) begin
      fails++;
      $display("FAIL rstmid_after: q=%h ack0=%b busy=%b, want 0", q, ack0, busy);
    end
  endtask

`ifdef SR_BANK_CLEAR_ALL_EN
  task automatic test_clr_all();
    do_write(1'b0, 3'd0, 1'b1);
    do_write(1'b1, 3'd2, 1'b1);
    do_write(1'b0, 3'd5, 1'b1);
    do_write(1'b1, 3'd7, 1'b1);            // q = A5, rr -> 0
    clr_all = 1'b1;
    req0 = 1'b1; addr0 = 3'd3; d0 = 1'b1;
    @(negedge clk);
    clr_all = 1'b0;
    tests++;
    if ({s, r} !== {8'h00, 8'hA5}) begin
      fails++;
      $display("FAIL clrall_drive: s=%h r=%h, want 00 a5", s, r);
    end
    @(negedge clk);
    tests++;
    if ({ack0, ack1, q} !== {2'b00, 8'h00}) begin
      fails++;
      $display("FAIL clrall_ack: ack=%b%b q=%h, want 00 00", ack0, ack1, q);
    end
    @(negedge clk);
    @(negedge clk);
    req0 = 1'b0;
    tests++;
    if (s !== 8'h08) begin
      fails++;
      $display("FAIL clrall_req0: s=%h, want 08", s);
    end
    @(negedge clk);
    tests++;
    if ({ack0, q} !== {1'b1, 8'h08}) begin
      fails++;
      $display("FAIL clrall_req0_ack: ack0=%b q=%h, want 1 08", ack0, q);
    end
    @(negedge clk);
  endtask
`endif

  // s/r exclusivity and at-most-one-hot (clear-all may raise several r bits)
  always @(negedge clk) begin
    if (rst_n) begin
      tests++;
      if ((s & r) !== 8'h00) begin
        fails++;
        $display("FAIL sr_overlap: s=%h r=%h", s, r);
      end
`ifndef SR_BANK_CLEAR_ALL_EN
      if ($countones(s | r) > 1) begin
        fails++;
        $display("FAIL sr_onehot: s=%h r=%h", s, r);
      end
`endif
    end
  end

  initial begin
    test_reset();
    test_set_bit5();
    test_clear_bit5();
    test_collision();
    test_noop();
    test_rr_alternate();
    test_reset_mid();
`ifdef SR_BANK_CLEAR_ALL_EN
    test_clr_all();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
